lab5_mcore_dcache_port_arbiter: RTL and testbench

Memory-side responder for the four per-core data-cache request/response ports of the quad-core tile. It arbitrates the four cores' `mem_req_4B_t` streams round-robin onto a single shared memory request port. It records which core issued each request in an in-order tracking FIFO, and steers each in-order memory response back to the issuing core.

---
 rtl/lab5_mcore_dcache_port_arbiter.sv | 107 ++++++++++
 tb/tb_lab5_mcore_dcache_port_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lab5_mcore_dcache_port_arbiter.sv
// Round-robin arbiter from four core dcache ports onto one memory port.
// An in-order tracking FIFO steers each memory response back to its core.
module lab5_mcore_dcache_port_arbiter #(
  parameter int unsigned p_num_ports   = 4,
  parameter int unsigned p_track_depth = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [p_num_ports-1:0][76:0]     core_req_msg,
  input  logic [p_num_ports-1:0]           core_req_val,
  output logic [p_num_ports-1:0]           core_req_rdy,
  output logic [p_num_ports-1:0][46:0]     core_resp_msg,
  output logic [p_num_ports-1:0]           core_resp_val,
  input  logic [p_num_ports-1:0]           core_resp_rdy,
  output logic [76:0]                      memreq_msg,
  output logic                             memreq_val,
  input  logic                             memreq_rdy,
  input  logic [46:0]                      memresp_msg,
  input  logic                             memresp_val,
  output logic                             memresp_rdy
);

  localparam int unsigned id_w  = $clog2(p_num_ports);
  localparam int unsigned ptr_w = $clog2(p_track_depth);
  localparam int unsigned cnt_w = $clog2(p_track_depth + 1);

  typedef logic [id_w-1:0] id_t;

  id_t              prio;
  id_t              grant;
  id_t              head;
  id_t              track [p_track_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;
  logic             full;
  logic             empty;
  logic             req_ok;
  logic             push;
  logic             pop;

  assign full  = (count == cnt_w'(p_track_depth));
  assign empty = (count == '0);

  // Rotating search starting at prio; falls back to prio when nobody asks.
  always_comb begin
    id_t  idx;
    logic found;
    grant = prio;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < p_num_ports; i++) begin
      idx = id_t'((32'(prio) + i) % p_num_ports);
      if (!found && core_req_val[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Full is the registered state, so a same-cycle pop never admits a push.
  assign req_ok     = !reset && !full;
  assign memreq_val = (|core_req_val) && req_ok;
  assign memreq_msg = core_req_msg[grant];
  assign push       = memreq_val && memreq_rdy;

  always_comb begin
    core_req_rdy        = '0;
    core_req_rdy[grant] = memreq_rdy && req_ok;
  end

  assign head        = track[rd_ptr];
  assign memresp_rdy = !reset && !empty && core_resp_rdy[head];
  assign pop         = memresp_val && memresp_rdy;

  always_comb begin
    core_resp_val       = '0;
    core_resp_val[head] = memresp_val && !empty && !reset;
    for (int unsigned i = 0; i < p_num_ports; i++) begin
      core_resp_msg[i] = memresp_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        track[wr_ptr] <= grant;
        wr_ptr <= (wr_ptr == ptr_w'(p_track_depth - 1)) ? '0 : wr_ptr + 1'b1;
        prio   <= (grant == id_t'(p_num_ports - 1)) ? '0 : grant + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == ptr_w'(p_track_depth - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_lab5_mcore_dcache_port_arbiter.sv
// Directed vector bench for the quad-core dcache port arbiter.
module tb_lab5_mcore_dcache_port_arbiter;

  logic             clk;
  logic             reset;
  logic [3:0][76:0] core_req_msg;
  logic [3:0]       core_req_val;
  logic [3:0]       core_req_rdy;
  logic [3:0][46:0] core_resp_msg;
  logic [3:0]       core_resp_val;
  logic [3:0]       core_resp_rdy;
  logic [76:0]      memreq_msg;
  logic             memreq_val;
  logic             memreq_rdy;
  logic [46:0]      memresp_msg;
  logic             memresp_val;
  logic             memresp_rdy;

  lab5_mcore_dcache_port_arbiter #(.p_num_ports(4), .p_track_depth(4)) dut (
    .clk(clk), .reset(reset),
    .core_req_msg(core_req_msg), .core_req_val(core_req_val), .core_req_rdy(core_req_rdy),
    .core_resp_msg(core_resp_msg), .core_resp_val(core_resp_val), .core_resp_rdy(core_resp_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic       mrdy;
    logic       rspv;
    logic [3:0] rrdy;
    logic       mval;
    logic [3:0] crdy;
    logic [1:0] gnt;
    logic [3:0] cval;
    logic       mresprdy;
  } vec_t;

  int ncmp  = 0;
  int nfail = 0;
  int step_no = 0;

  // core 2's message is a read of 0x1000 with opaque 0x05
  function automatic logic [76:0] msg_of(input int i);
    return {3'd0, 8'(8'h03 + i), 32'(32'h0FF8 + 4 * i), 2'd0, 32'(32'hA000 + i)};
  endfunction

  function automatic logic [46:0] resp_of(input int k);
    return {3'd0, 8'h05, 2'd0, 2'd0, 32'(32'hCAFEF00D + k)};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [3:0] rv, input logic mrdy,
                              input logic rspv, input logic [3:0] rrdy, input logic mval,
                              input logic [3:0] crdy, input logic [1:0] gnt,
                              input logic [3:0] cval, input logic mresprdy);
    vec_t v;
    v.rst = rst; v.rv = rv; v.mrdy = mrdy; v.rspv = rspv; v.rrdy = rrdy;
    v.mval = mval; v.crdy = crdy; v.gnt = gnt; v.cval = cval; v.mresprdy = mresprdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [76:0] got, input logic [76:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s step %0d: got %h want %h", name, step_no, got, exp);
    end
  endtask

  // Drive just after the rising edge, compare mid-cycle before the next one.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    reset         = v.rst;
    core_req_val  = v.rv;
    memreq_rdy    = v.mrdy;
    memresp_val   = v.rspv;
    core_resp_rdy = v.rrdy;
    memresp_msg   = resp_of(step_no);
    #3;
    chk("memreq_val", 77'(memreq_val), 77'(v.mval));
    if (v.rv != 4'b0000) chk("core_req_rdy", 77'(core_req_rdy), 77'(v.crdy));
    if (v.mval) chk("memreq_msg", memreq_msg, msg_of(int'(v.gnt)));
    chk("core_resp_val", 77'(core_resp_val), 77'(v.cval));
    chk("memresp_rdy", 77'(memresp_rdy), 77'(v.mresprdy));
    for (int i = 0; i < 4; i++) chk("core_resp_msg", 77'(core_resp_msg[i]), 77'(resp_of(step_no)));
    step_no++;
  endtask

  vec_t vt [22];
  int   cores [7] = '{1, 3, 0, 2, 2, 1, 3};

  initial begin
    reset = 1'b1;
    core_req_val = '0; memreq_rdy = 1'b0; memresp_val = 1'b0;
    core_resp_rdy = '0; memresp_msg = '0;
    for (int i = 0; i < 4; i++) core_req_msg[i] = msg_of(i);

    //          rst  rv     mrdy rspv rrdy     mval crdy   g  cval   mrsprdy
    vt[0]  = mk(1, 4'hF, 1, 1, 4'hF,   0, 4'h0, 0, 4'h0, 0);
    vt[1]  = mk(0, 4'h0, 1, 0, 4'hF,   0, 4'h0, 0, 4'h0, 0);
    vt[2]  = mk(0, 4'h4, 1, 0, 4'hF,   1, 4'h4, 2, 4'h0, 0);  // core 2 read
    vt[3]  = mk(0, 4'h0, 1, 1, 4'hF,   0, 4'h0, 0, 4'h4, 1);  // response to core 2
    vt[4]  = mk(1, 4'hF, 1, 1, 4'hF,   0, 4'h0, 0, 4'h0, 0);
    vt[5]  = mk(0, 4'hF, 1, 0, 4'hF,   1, 4'h1, 0, 4'h0, 0);  // all cores valid
    vt[6]  = mk(0, 4'hF, 1, 1, 4'hF,   1, 4'h2, 1, 4'h1, 1);
    vt[7]  = mk(0, 4'hF, 1, 1, 4'hF,   1, 4'h4, 2, 4'h2, 1);
    vt[8]  = mk(0, 4'hF, 1, 1, 4'hF,   1, 4'h8, 3, 4'h4, 1);
    vt[9]  = mk(0, 4'hF, 1, 1, 4'hF,   1, 4'h1, 0, 4'h8, 1);
    vt[10] = mk(0, 4'hF, 1, 0, 4'hF,   1, 4'h2, 1, 4'h0, 1);  // memory withholds
    vt[11] = mk(0, 4'hF, 1, 0, 4'hF,   1, 4'h4, 2, 4'h0, 1);
    vt[12] = mk(0, 4'hF, 1, 0, 4'hF,   1, 4'h8, 3, 4'h0, 1);
    vt[13] = mk(0, 4'hF, 1, 0, 4'hF,   0, 4'h0, 0, 4'h0, 1);  // full
    vt[14] = mk(0, 4'hF, 1, 1, 4'hF,   0, 4'h0, 0, 4'h1, 1);  // pop while full: no push
    vt[15] = mk(0, 4'hF, 1, 0, 4'hF,   1, 4'h1, 0, 4'h0, 1);  // re-enabled next cycle
    vt[16] = mk(0, 4'h0, 1, 1, 4'hD,   0, 4'h0, 0, 4'h2, 0);  // head core 1 not ready
    vt[17] = mk(0, 4'h0, 1, 1, 4'hD,   0, 4'h0, 0, 4'h2, 0);
    vt[18] = mk(0, 4'h0, 1, 1, 4'hF,   0, 4'h0, 0, 4'h2, 1);
    vt[19] = mk(1, 4'hF, 1, 1, 4'hF,   0, 4'h0, 0, 4'h0, 0);  // reset with 3 in flight
    vt[20] = mk(0, 4'h8, 1, 0, 4'hF,   1, 4'h8, 3, 4'h0, 0);
    vt[21] = mk(0, 4'h0, 1, 1, 4'hF,   0, 4'h0, 0, 4'h8, 1);

    for (int k = 0; k < 22; k++) step(vt[k]);

    // Seven single-core requests, each overlapping the previous response.
    for (int j = 0; j < 8; j++) begin
      logic [3:0] rv;
      logic [3:0] cv;
      rv = (j < 7) ? 4'(1 << cores[j]) : 4'h0;
      cv = (j > 0) ? 4'(1 << cores[j-1]) : 4'h0;
      step(mk(0, rv, 1, (j > 0), 4'hF, (j < 7), rv,
              (j < 7) ? 2'(cores[j]) : 2'd0, cv, (j > 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
